// File: rtl/bus_demux4.sv
// bus_demux4: routes one CPU data-memory request to one of four memory-mapped slaves
// Optional feature: define BUS_DEMUX_TIMEOUT_EN to abort an unanswered ISSUE after TIMEOUT cycles
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready CPU request handshake; req_ready is high only in IDLE
//   req_we/addr/wdata/be CPU request fields, latched on acceptance
//   resp_valid          one-cycle response strobe
//   resp_rdata/resp_err response data/error, held until the next response
//   s_valid             one-hot request strobe to the slave selected by addr[SEL_LO+1:SEL_LO]
//   s_ready             per-slave accept; only the selected slave's bit is used
//   s_we/s_be/s_addr/s_wdata latched request fields shared by all slaves
//   s_rdata             packed slave read data, slave i on [W*i +: W]
module bus_demux4 #(
    parameter int         W        = 32,
    parameter int         SEL_LO   = 28,
    parameter logic [3:0] MAP_MASK = 4'b1111,
    parameter int         TIMEOUT  = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [W-1:0]   req_addr,
    input  logic [W-1:0]   req_wdata,
    input  logic [3:0]     req_be,
    output logic           resp_valid,
    output logic [W-1:0]   resp_rdata,
    output logic           resp_err,
    output logic [3:0]     s_valid,
    input  logic [3:0]     s_ready,
    output logic           s_we,
    output logic [3:0]     s_be,
    output logic [W-1:0]   s_addr,
    output logic [W-1:0]   s_wdata,
    input  logic [4*W-1:0] s_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t       state, nxt;
    logic [1:0]   idx;
    logic [1:0]   req_idx;
    logic         hit;
    logic         expired;
    logic [W-1:0] rd [4];
    assign req_idx = req_addr[SEL_LO+1:SEL_LO];
    assign hit     = s_ready[idx];
    for (genvar i = 0; i < 4; i++) begin : g_rd
        assign rd[i] = s_rdata[W*i +: W];
    end
`ifdef BUS_DEMUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // Held at zero outside ISSUE so it starts from zero on every entry.
    always_ff @(posedge clk)
        cnt <= (rst || state != ISSUE) ? '0 : cnt + 1'b1;
    assign expired = cnt == CW'(TIMEOUT - 1);
`else
    assign expired = 1'b0;
`endif
    always_ff @(posedge clk)
        state <= rst ? IDLE : nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req_valid ? (MAP_MASK[req_idx] ? ISSUE : RESP) : IDLE;
            ISSUE:   nxt = (hit || expired) ? RESP : ISSUE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        req_ready  = state == IDLE;
        resp_valid = state == RESP;
        s_valid    = (state == ISSUE) ? 4'b0001 << idx : 4'b0000;
    end
    // Response fields are loaded only when entering RESP, so they hold between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            s_we       <= 1'b0;
            s_be       <= '0;
            s_addr     <= '0;
            s_wdata    <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else if (state == IDLE && req_valid) begin
            idx     <= req_idx;
            s_we    <= req_we;
            s_be    <= req_be;
            s_addr  <= req_addr;
            s_wdata <= req_wdata;
            if (!MAP_MASK[req_idx]) begin
                resp_err   <= 1'b1;
                resp_rdata <= '0;
            end
        end else if (state == ISSUE && (hit || expired)) begin
            resp_err   <= !hit;
            resp_rdata <= (hit && !s_we) ? rd[idx] : '0;
        end
    end
endmodule

// File: tb/tb_bus_demux4.sv
// tb_bus_demux4: directed table-driven bench for bus_demux4
module tb_bus_demux4;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_we;
    logic [31:0]  req_addr, req_wdata;
    logic [3:0]   req_be;
    logic         req_ready, resp_valid, resp_err, s_we;
    logic [31:0]  resp_rdata, s_addr, s_wdata;
    logic [3:0]   s_valid, s_ready, s_be;
    logic [127:0] s_rdata;
    logic         v1, u1_ready, u1_rv, u1_err, u1_we;
    logic [31:0]  u1_rd, u1_addr, u1_wdata;
    logic [3:0]   u1_sv, u1_be;
    logic [3:0]   u1_s_ready;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bus_demux4 #(.W(32), .SEL_LO(28), .MAP_MASK(4'b1111), .TIMEOUT(8)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .s_valid(s_valid), .s_ready(s_ready),
        .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata)
    );

    bus_demux4 #(.W(32), .SEL_LO(28), .MAP_MASK(4'b0111), .TIMEOUT(8)) u1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(u1_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(u1_rv),
        .resp_rdata(u1_rd), .resp_err(u1_err), .s_valid(u1_sv), .s_ready(u1_s_ready),
        .s_we(u1_we), .s_be(u1_be), .s_addr(u1_addr), .s_wdata(u1_wdata), .s_rdata(s_rdata)
    );

    typedef struct {
        string       nm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;
        int          lat;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request; unselected slaves assert s_ready during stall cycles to show they are ignored.
    task automatic run(input string nm, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int stall, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        int iss;
        int fbad;
        logic [3:0] oh;
        oh = 4'b0001 << addr[29:28];
        chk({nm, ":ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        tick();
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd; req_be = ~be;
        lat = 1; iss = 0; fbad = 0;
        while (!resp_valid && lat < 200) begin
            if (s_valid != oh || s_addr != addr || s_wdata != wd || s_be != be || s_we != we || req_ready)
                fbad++;
            iss++;
            s_ready = (iss > stall) ? oh : ~oh;
            tick();
            lat++;
        end
        s_ready = 4'b0000;
        chk({nm, ":issue_fields"}, 32'(fbad), 32'd0);
        chk({nm, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, ":rdata"}, resp_rdata, exp_rd);
        chk({nm, ":err"}, 32'(resp_err), 32'(exp_err));
        chk({nm, ":sv_in_resp"}, 32'(s_valid), 32'd0);
        chk({nm, ":ready_in_resp"}, 32'(req_ready), 32'd0);
        tick();
        chk({nm, ":one_cycle"}, 32'(resp_valid), 32'd0);
        chk({nm, ":rdata_hold"}, resp_rdata, exp_rd);
        chk({nm, ":err_hold"}, 32'(resp_err), 32'(exp_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{"rd_s0",      1'b0, 32'h0000_0010, 32'h0,         4'hF,    0, 2, 32'h1234_5678};
        vecs[1] = '{"wr_s2",      1'b1, 32'h2000_0004, 32'hCAFE_F00D, 4'b0011, 3, 5, 32'h0};
        vecs[2] = '{"rd_s1",      1'b0, 32'h1000_0008, 32'h0,         4'hF,    1, 3, 32'hB111_1111};
        vecs[3] = '{"rd_s3_noise", 1'b0, 32'h3000_0000, 32'h0,        4'hF,    2, 4, 32'hD333_3333};
        vecs[4] = '{"wr_s0",      1'b1, 32'h0000_0000, 32'h5A5A_A5A5, 4'b1000, 0, 2, 32'h0};
        vecs[5] = '{"rd_s2",      1'b0, 32'h2FFF_FFFF, 32'h0,         4'b0110, 2, 4, 32'hC222_2222};
        s_rdata = {32'hD333_3333, 32'hC222_2222, 32'hB111_1111, 32'h1234_5678};
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        s_ready = 4'b0000; v1 = 1'b0; u1_s_ready = 4'b1111;
        tick();
        tick();
        chk("reset:s_valid", 32'(s_valid), 32'd0);
        chk("reset:resp_valid", 32'(resp_valid), 32'd0);
        chk("reset:resp_err", 32'(resp_err), 32'd0);
        chk("reset:resp_rdata", resp_rdata, 32'd0);
        chk("reset:s_addr", s_addr, 32'd0);
        chk("reset:s_wdata", s_wdata, 32'd0);
        chk("reset:s_be_we", {27'd0, s_be, s_we}, 32'd0);
        chk("reset:req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 6; i++)
            run(vecs[i].nm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                vecs[i].stall, vecs[i].lat, vecs[i].rd, 1'b0);

        // Reset during ISSUE: no response, back to IDLE, then a normal transaction.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1000_0000; req_wdata = 32'h1111_2222; req_be = 4'hF;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rst_mid:in_issue", 32'(s_valid), 32'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid:s_valid", 32'(s_valid), 32'd0);
        chk("rst_mid:req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid:resp_valid", 32'(resp_valid), 32'd0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid || s_valid != 0) n++;
        end
        chk("rst_mid:quiet_after", 32'(n), 32'd0);
        run("after_rst", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 2, 32'h1234_5678, 1'b0);

        // Unmapped index on the instance whose slave 3 is absent.
        v1 = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
        tick();
        v1 = 1'b0;
        tick();
        chk("u1_map:resp_valid", 32'(u1_rv), 32'd1);
        chk("u1_map:rdata", u1_rd, 32'h1234_5678);
        tick();
        v1 = 1'b1; req_addr = 32'h3000_0000;
        tick();
        v1 = 1'b0;
        chk("unmapped:resp_at_n1", 32'(u1_rv), 32'd1);
        chk("unmapped:err", 32'(u1_err), 32'd1);
        chk("unmapped:rdata", u1_rd, 32'd0);
        chk("unmapped:no_s_valid", 32'(u1_sv), 32'd0);
        tick();
        chk("unmapped:one_cycle", 32'(u1_rv), 32'd0);
        chk("unmapped:err_hold", 32'(u1_err), 32'd1);
        chk("unmapped:ready_after", 32'(u1_ready), 32'd1);

        // Slave that never answers.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2000_0000;
        tick();
        req_valid = 1'b0;
`ifdef BUS_DEMUX_TIMEOUT_EN
        n = 1;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("timeout:latency", 32'(n), 32'd9);
        chk("timeout:err", 32'(resp_err), 32'd1);
        chk("timeout:rdata", resp_rdata, 32'd0);
        chk("timeout:s_valid", 32'(s_valid), 32'd0);
        tick();
        run("ready_at_limit", 1'b0, 32'h1000_0000, 32'h0, 4'hF, 7, 9, 32'hB111_1111, 1'b0);
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (s_valid != 4'b0100 || resp_valid) n++;
            tick();
        end
        chk("no_timeout:still_issue", 32'(n), 32'd0);
        chk("no_timeout:s_valid", 32'(s_valid), 32'b0100);
        s_ready = 4'b0100;
        tick();
        s_ready = 4'b0000;
        chk("no_timeout:resp", 32'(resp_valid), 32'd1);
        chk("no_timeout:rdata", resp_rdata, 32'hC222_2222);
        chk("no_timeout:err", 32'(resp_err), 32'd0);
        tick();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
